periph_arbiter: RTL and testbench

Two-master arbiter that shares the single data-memory/GPIO port of the peripheral block between the CPU data path (master 0) and a secondary bus master such as a program loader or DMA engine (master 1). It sits between the masters and the peripheral's `dm_w`/`dm_r`/`addr`/`wdata`/`dm_op`/`rdata` port. It serialises accesses with a registered req/gnt/ack handshake and round-robin priority. An optional bounded bus lock lets master 1 hold the port for bursts.

---
 rtl/periph_arbiter_if.sv | 56 +++++
 rtl/periph_arbiter.sv | 175 +++++++++++++++++
 tb/tb_periph_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/periph_arbiter_if.sv
// periph_arbiter_if: two request ports and one peripheral port.
// slave = arbiter view; master = requesters plus peripheral.
interface periph_arbiter_if;
  // master 0: CPU data path
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [2:0]  m0_op;
  logic        m0_gnt;
  logic        m0_ack;
  logic [31:0] m0_rdata;

  // master 1: loader / DMA
  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [2:0]  m1_op;
  logic        m1_lock;
  logic        m1_gnt;
  logic        m1_ack;
  logic [31:0] m1_rdata;

  // peripheral data-memory / GPIO port
  logic        dm_w;
  logic        dm_r;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  dm_op;
  logic [31:0] rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr,
    input  m0_wdata, m0_op,
    output m0_gnt, m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_addr,
    input  m1_wdata, m1_op, m1_lock,
    output m1_gnt, m1_ack, m1_rdata,
    output dm_w, dm_r, addr,
    output wdata, dm_op,
    input  rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr,
    output m0_wdata, m0_op,
    input  m0_gnt, m0_ack, m0_rdata,
    output m1_req, m1_we, m1_addr,
    output m1_wdata, m1_op, m1_lock,
    input  m1_gnt, m1_ack, m1_rdata,
    input  dm_w, dm_r, addr,
    input  wdata, dm_op,
    output rdata
  );
endinterface

// File: rtl/periph_arbiter.sv
// periph_arbiter: round-robin 2-master arbiter for the
// peripheral dm port. IDLE/ACCESS/RESP, gnt->ack 2 cycles.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous reset, active low
//   bus  - periph_arbiter_if.slave: m0/m1 req, we, addr,
//          wdata, op, gnt, ack, rdata; m1_lock; slave
//          dm_w, dm_r, addr, wdata, dm_op, rdata
// Parameter:
//   LOCK_MAX - max consecutive locked m1 grants
// Build option:
//   ARB_LOCK_EN - enables the bounded m1 bus lock;
//   undefined gives pure round-robin, m1_lock ignored.
module periph_arbiter #(
  parameter int unsigned LOCK_MAX = 8
) (
  input logic             clk,
  input logic             rst,
  periph_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]  state;
  logic        last;
  logic        owner;
  logic        we_q;
  logic        dm_w_q;
  logic        dm_r_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  op_q;
  logic        ack0_q;
  logic        ack1_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;

  logic        arb_en;
  logic        tie0;
  logic        pick0;
  logic        pick1;
  logic        win0;
  logic        win1;
  logic        win;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_op;

  // Arbitration runs in IDLE and RESP only; nothing
  // is outstanding there, so req alone means eligible.
  // rst gates the combinational grant during reset.
  assign arb_en = rst &&
                  ((state == IDLE) || (state == RESP));

`ifdef ARB_LOCK_EN
  localparam int unsigned CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_LIM = CW'(LOCK_MAX);

  logic [CW-1:0] lock_cnt;
  logic          lock_on;
  logic          lock_exp;

  // A nonzero count means the last m1 grant was locked
  // and m0 has not been served since.
  assign lock_on  = (lock_cnt != '0);
  assign lock_exp = (lock_cnt >= LOCK_LIM);
  assign tie0     = lock_on ? lock_exp : last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_cnt <= '0;
    end else if (win0) begin
      lock_cnt <= '0;
    end else if (win1) begin
      if (!bus.m1_lock) begin
        lock_cnt <= '0;
      end else if (!lock_exp) begin
        lock_cnt <= lock_cnt + CW'(1);
      end
    end
  end
`else
  // last = 1 means m1 was served last: m0 wins a tie
  assign tie0 = last;
`endif

  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    unique case (1'b1)
      (bus.m0_req && !bus.m1_req): pick0 = 1'b1;
      (!bus.m0_req && bus.m1_req): pick1 = 1'b1;
      (bus.m0_req && bus.m1_req): begin
        pick0 = tie0;
        pick1 = !tie0;
      end
      default: ;
    endcase
  end

  assign win0 = arb_en && pick0;
  assign win1 = arb_en && pick1;
  assign win  = win0 || win1;

  assign sel_we    = win1 ? bus.m1_we    : bus.m0_we;
  assign sel_addr  = win1 ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = win1 ? bus.m1_wdata : bus.m0_wdata;
  assign sel_op    = win1 ? bus.m1_op    : bus.m0_op;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      owner    <= 1'b0;
      we_q     <= 1'b0;
      dm_w_q   <= 1'b0;
      dm_r_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_q     <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      dm_w_q <= 1'b0;
      dm_r_q <= 1'b0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      unique case (state)
        IDLE, RESP: begin
          if (win) begin
            state   <= ACCESS;
            owner   <= win1;
            last    <= win1;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            op_q    <= sel_op;
            dm_w_q  <= sel_we;
            dm_r_q  <= !sel_we;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          // slave rdata settles within ACCESS
          state  <= RESP;
          ack0_q <= !owner;
          ack1_q <= owner;
          if (!we_q && !owner) rdata0_q <= bus.rdata;
          if (!we_q && owner)  rdata1_q <= bus.rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m0_gnt   = win0;
  assign bus.m1_gnt   = win1;
  assign bus.m0_ack   = ack0_q;
  assign bus.m1_ack   = ack1_q;
  assign bus.m0_rdata = rdata0_q;
  assign bus.m1_rdata = rdata1_q;
  assign bus.dm_w     = dm_w_q;
  assign bus.dm_r     = dm_r_q;
  assign bus.addr     = addr_q;
  assign bus.wdata    = wdata_q;
  assign bus.dm_op    = op_q;

endmodule

// File: tb/tb_periph_arbiter.sv
// tb_periph_arbiter: directed checks of periph_arbiter
// against a small memory + GPIO slave model.
module tb_periph_arbiter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  periph_arbiter_if bus();

  periph_arbiter #(
    .LOCK_MAX(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // slave model: 16-word memory, switches at BF800004,
  // LED at BF800000 (write-only, not stored)
  logic [31:0] mem [16];
  logic [15:0] sw;

  always_comb begin
    if (bus.addr == 32'hBF80_0004) bus.rdata = {16'd0, sw};
    else bus.rdata = mem[bus.addr[5:2]];
  end

  always @(negedge clk) begin
    if (bus.dm_w && bus.addr[31:28] != 4'hB)
      mem[bus.addr[5:2]] = bus.wdata;
  end

  task automatic chk1(input string tag,
                      input logic obs,
                      input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b",
             tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  logic exp_win [10];
  logic w;
  logic ev;

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    sw  = 16'h00A5;
    for (int i = 0; i < 16; i++)
      mem[i] = 32'h1111_0000 | i;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_op = 0;
    bus.m0_addr = 0; bus.m0_wdata = 0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_op = 0;
    bus.m1_addr = 0; bus.m1_wdata = 0;
    bus.m1_lock = 0;
`ifdef ARB_LOCK_EN
    exp_win = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
`else
    exp_win = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
`endif

    // reset state, requests present but masked
    repeat (3) @(negedge clk);
    bus.m0_req = 1; bus.m1_req = 1;
    #1;
    chk1("rst_gnt0", bus.m0_gnt, 1'b0);
    chk1("rst_gnt1", bus.m1_gnt, 1'b0);
    chk1("rst_dm_w", bus.dm_w, 1'b0);
    chk1("rst_dm_r", bus.dm_r, 1'b0);
    chk1("rst_ack0", bus.m0_ack, 1'b0);
    chk32("rst_addr", bus.addr, 32'h0);
    chk32("rst_m0_rdata", bus.m0_rdata, 32'h0);
    bus.m0_req = 0; bus.m1_req = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // m0 write 0x10 then read it back
    bus.m0_req = 1; bus.m0_we = 1; bus.m0_op = 3'd2;
    bus.m0_addr = 32'h10; bus.m0_wdata = 32'hDEAD_BEEF;
    #1;
    chk1("wr_gnt0", bus.m0_gnt, 1'b1);
    chk1("wr_gnt1", bus.m1_gnt, 1'b0);
    @(negedge clk);
    bus.m0_req = 0;
    chk1("wr_dm_w", bus.dm_w, 1'b1);
    chk1("wr_dm_r", bus.dm_r, 1'b0);
    chk32("wr_addr", bus.addr, 32'h10);
    chk32("wr_wdata", bus.wdata, 32'hDEAD_BEEF);
    chk32("wr_op", {29'd0, bus.dm_op}, 32'd2);
    chk1("wr_ack_early", bus.m0_ack, 1'b0);
    @(negedge clk);
    chk1("wr_ack", bus.m0_ack, 1'b1);
    chk1("wr_dm_w_off", bus.dm_w, 1'b0);
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_op = 3'd5;
    #1;
    chk1("rd_gnt_in_ack", bus.m0_gnt, 1'b1);
    @(negedge clk);
    bus.m0_req = 0;
    chk1("rd_dm_r", bus.dm_r, 1'b1);
    chk1("rd_dm_w", bus.dm_w, 1'b0);
    chk32("rd_op", {29'd0, bus.dm_op}, 32'd5);
    chk32("wr_no_rdata", bus.m0_rdata, 32'h0);
    @(negedge clk);
    chk1("rd_ack", bus.m0_ack, 1'b1);
    chk1("rd_dm_r_off", bus.dm_r, 1'b0);
    chk32("rd_rdata", bus.m0_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    chk1("idle_ack", bus.m0_ack, 1'b0);
    chk32("rd_hold", bus.m0_rdata, 32'hDEAD_BEEF);

    // both request continuously, 10 grants
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_op = 3'd1;
    bus.m0_addr = 32'h10;
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_op = 3'd1;
    bus.m1_addr = 32'h14; bus.m1_lock = 1;
    for (int k = 0; k < 21; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 19) begin
        bus.m0_req = 0;
        bus.m1_req = 0;
      end
      #1;
      ev = ((k % 2) == 0);
      w  = (k < 20) ? exp_win[k / 2] : 1'b0;
      chk1("rr_gnt0", bus.m0_gnt, ev && k < 20 && !w);
      chk1("rr_gnt1", bus.m1_gnt, ev && k < 20 && w);
      w  = (k >= 2) ? exp_win[(k / 2 + 9) % 10] : 1'b0;
      chk1("rr_ack0", bus.m0_ack, ev && k >= 2 && !w);
      chk1("rr_ack1", bus.m1_ack, ev && k >= 2 && w);
      chk1("rr_dm_r", bus.dm_r, !ev);
      chk1("rr_excl", bus.dm_w, 1'b0);
    end
    chk32("rr_m0_rdata", bus.m0_rdata, 32'hDEAD_BEEF);
    chk32("rr_m1_rdata", bus.m1_rdata, 32'h1111_0005);
    bus.m1_lock = 0;
    @(negedge clk);

    // reset during m1 LED write
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_op = 3'd2;
    bus.m1_addr = 32'hBF80_0000;
    bus.m1_wdata = 32'h0000_0055;
    #1;
    chk1("led_gnt1", bus.m1_gnt, 1'b1);
    @(negedge clk);
    bus.m1_req = 0;
    chk1("led_dm_w", bus.dm_w, 1'b1);
    chk32("led_addr", bus.addr, 32'hBF80_0000);
    rst = 1'b0;
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_op = 3'd1;
    bus.m0_addr = 32'h10;
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_op = 3'd1;
    bus.m1_addr = 32'h14;
    @(negedge clk);
    chk1("mid_dm_w", bus.dm_w, 1'b0);
    chk1("mid_dm_r", bus.dm_r, 1'b0);
    chk1("mid_ack1", bus.m1_ack, 1'b0);
    chk1("mid_gnt0", bus.m0_gnt, 1'b0);
    chk1("mid_gnt1", bus.m1_gnt, 1'b0);
    chk32("mid_addr", bus.addr, 32'h0);
    chk32("mid_wdata", bus.wdata, 32'h0);
    chk32("mid_op", {29'd0, bus.dm_op}, 32'd0);
    chk32("mid_m0_rdata", bus.m0_rdata, 32'h0);
    chk32("mid_m1_rdata", bus.m1_rdata, 32'h0);
    rst = 1'b1;
    #1;
    chk1("tie_gnt0", bus.m0_gnt, 1'b1);
    chk1("tie_gnt1", bus.m1_gnt, 1'b0);
    @(negedge clk);
    bus.m0_req = 0;
    chk1("tie_dm_r0", bus.dm_r, 1'b1);
    chk32("tie_addr0", bus.addr, 32'h10);
    chk1("tie_wait1", bus.m1_gnt, 1'b0);
    @(negedge clk);
    chk1("tie_ack0", bus.m0_ack, 1'b1);
    chk32("tie_rdata0", bus.m0_rdata, 32'hDEAD_BEEF);
    chk1("tie_gnt1_resp", bus.m1_gnt, 1'b1);
    chk1("tie_gnt0_resp", bus.m0_gnt, 1'b0);
    @(negedge clk);
    bus.m1_req = 0;
    chk1("tie_dm_r1", bus.dm_r, 1'b1);
    chk32("tie_addr1", bus.addr, 32'h14);
    chk1("tie_ack_gap", bus.m1_ack, 1'b0);
    @(negedge clk);
    chk1("tie_ack1", bus.m1_ack, 1'b1);
    chk32("tie_rdata1", bus.m1_rdata, 32'h1111_0005);
    @(negedge clk);

    // GPIO switch read by m1
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_op = 3'd4;
    bus.m1_addr = 32'hBF80_0004;
    #1;
    chk1("sw_gnt1", bus.m1_gnt, 1'b1);
    @(negedge clk);
    bus.m1_req = 0;
    chk1("sw_dm_r", bus.dm_r, 1'b1);
    chk32("sw_addr", bus.addr, 32'hBF80_0004);
    chk32("sw_op", {29'd0, bus.dm_op}, 32'd4);
    @(negedge clk);
    chk1("sw_ack1", bus.m1_ack, 1'b1);
    chk32("sw_rdata", bus.m1_rdata, 32'h0000_00A5);
    chk32("sw_m0_keep", bus.m0_rdata, 32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
